// File: rtl/miriscv_csr_pkg.sv
// Shared CSR definitions for the miriscv core: machine XLEN, interrupt cause
// codes, mip bit positions, the interrupt front-end state type and an mcause
// builder for interrupt traps.
package miriscv_csr_pkg;

  localparam int unsigned MXLEN = 32;

  // Machine-level interrupt exception codes (mcause[3:0] with mcause[MXLEN-1]=1)
  localparam logic [3:0] INTERRUPT_MACHINE_SW    = 4'd3;
  localparam logic [3:0] INTERRUPT_MACHINE_TIMER = 4'd7;
  localparam logic [3:0] INTERRUPT_MACHINE_EXT   = 4'd11;

  // Live bit positions in mip/mie
  localparam int unsigned MIP_MSIP_BIT = 3;
  localparam int unsigned MIP_MTIP_BIT = 7;
  localparam int unsigned MIP_MEIP_BIT = 11;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_ACKED
  } irq_state_t;

  // mcause value for an interrupt: interrupt flag in the MSB, code zero-extended
  function automatic logic [MXLEN-1:0] irq_mcause(input logic [3:0] code);
    irq_mcause            = '0;
    irq_mcause[MXLEN-1]   = 1'b1;
    irq_mcause[3:0]       = code;
  endfunction

endpackage

// File: rtl/miriscv_sync_cell.sv
// N-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i    destination clock
//   rst_n_i  synchronous active-low reset, clears the whole chain
//   d_i      asynchronous input
//   q_o      synchronized output (last stage)
module miriscv_sync_cell #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Machine-level interrupt front end feeding the CSR/trap unit.
// Captures software/timer/external sources into mip, masks with mie and
// mstatus.MIE, arbitrates MEI > MSI > MTI and offers one request with its
// mcause over a req/ack handshake.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   irq_sw_i         machine software irq (level, clk_i domain)
//   irq_timer_i      machine timer irq (level, clk_i domain)
//   irq_ext_i        machine external irq (asynchronous)
//   mstatus_mie_i    global interrupt enable
//   mie_i            mie CSR (bits 3, 7, 11 used)
//   irq_req_o        request to CSR unit
//   irq_cause_o      mcause value of the request
//   irq_ack_i        CSR unit takes the trap this cycle
//   mip_o            mip CSR read value
module miriscv_irq_ctrl
  import miriscv_csr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXT_EDGE    = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             irq_sw_i,
  input  logic             irq_timer_i,
  input  logic             irq_ext_i,
  input  logic             mstatus_mie_i,
  input  logic [MXLEN-1:0] mie_i,
  output logic             irq_req_o,
  output logic [MXLEN-1:0] irq_cause_o,
  input  logic             irq_ack_i,
  output logic [MXLEN-1:0] mip_o
);

  logic             ext_s;
  logic             ext_prev_q;
  logic             msip_q, mtip_q, meip_q, meip_d;
  logic             meip_clr;
  logic             en_msi, en_mti, en_mei, en_any, en_latched;
  logic [3:0]       win_code;
  irq_state_t       state_q, state_d;
  logic [MXLEN-1:0] cause_q, cause_d;
  logic             unused_mie;

  miriscv_sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (irq_ext_i),
    .q_o     (ext_s)
  );

  assign unused_mie = ^{mie_i[MXLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    en_msi = msip_q & mie_i[MIP_MSIP_BIT] & mstatus_mie_i;
    en_mti = mtip_q & mie_i[MIP_MTIP_BIT] & mstatus_mie_i;
    en_mei = meip_q & mie_i[MIP_MEIP_BIT] & mstatus_mie_i;
    en_any = en_msi | en_mti | en_mei;
  end

  always_comb begin
    win_code = INTERRUPT_MACHINE_TIMER;
    if (en_mei) begin
      win_code = INTERRUPT_MACHINE_EXT;
    end else if (en_msi) begin
      win_code = INTERRUPT_MACHINE_SW;
    end
  end

  // Enable of the source that was latched at REQ entry, for withdraw detection
  always_comb begin
    en_latched = 1'b0;
    case (cause_q[3:0])
      INTERRUPT_MACHINE_EXT:   en_latched = en_mei;
      INTERRUPT_MACHINE_SW:    en_latched = en_msi;
      INTERRUPT_MACHINE_TIMER: en_latched = en_mti;
      default:                 en_latched = 1'b0;
    endcase
  end

  // Edge mode: a new rising edge in the same cycle as the ack clear wins
  always_comb begin
    meip_clr = irq_ack_i && (state_q == IRQ_REQ) &&
               (cause_q[3:0] == INTERRUPT_MACHINE_EXT);
    if (EXT_EDGE != 0) begin
      meip_d = (ext_s & ~ext_prev_q) | (meip_q & ~meip_clr);
    end else begin
      meip_d = ext_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IRQ_IDLE: begin
        if (en_any) begin
          state_d = IRQ_REQ;
          cause_d = irq_mcause(win_code);
        end
      end
      IRQ_REQ: begin
        if (irq_ack_i) begin
          state_d = IRQ_ACKED;
        end else if (!en_latched) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_ACKED: state_d = IRQ_IDLE;
      default:   state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      ext_prev_q <= 1'b0;
      state_q    <= IRQ_IDLE;
      cause_q    <= '0;
    end else begin
      msip_q     <= irq_sw_i;
      mtip_q     <= irq_timer_i;
      meip_q     <= meip_d;
      ext_prev_q <= ext_s;
      state_q    <= state_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    mip_o               = '0;
    mip_o[MIP_MSIP_BIT] = msip_q;
    mip_o[MIP_MTIP_BIT] = mtip_q;
    mip_o[MIP_MEIP_BIT] = meip_q;
  end

  assign irq_req_o   = (state_q == IRQ_REQ);
  assign irq_cause_o = cause_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Bench for miriscv_irq_ctrl: a level-mode instance (SYNC_STAGES=2) and an
// edge-mode instance (SYNC_STAGES=3) share one set of directed stimulus.
// A cycle-level reference model is compared every cycle, plus literal checks.
module tb_miriscv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_sw, irq_timer, irq_ext, mst, ack;
  logic [31:0] mie;

  logic        req0, req1;
  logic [31:0] cause0, cause1, mip0, mip1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  miriscv_irq_ctrl #(.SYNC_STAGES(2), .EXT_EDGE(0)) dut_lvl (
    .clk_i(clk), .rst_n_i(rst_n), .irq_sw_i(irq_sw), .irq_timer_i(irq_timer),
    .irq_ext_i(irq_ext), .mstatus_mie_i(mst), .mie_i(mie),
    .irq_req_o(req0), .irq_cause_o(cause0), .irq_ack_i(ack), .mip_o(mip0)
  );

  miriscv_irq_ctrl #(.SYNC_STAGES(3), .EXT_EDGE(1)) dut_edg (
    .clk_i(clk), .rst_n_i(rst_n), .irq_sw_i(irq_sw), .irq_timer_i(irq_timer),
    .irq_ext_i(irq_ext), .mstatus_mie_i(mst), .mie_i(mie),
    .irq_req_o(req1), .irq_cause_o(cause1), .irq_ack_i(ack), .mip_o(mip1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outputs after each edge derived from: mip = inputs delayed by the capture
  // path, request offered while enabled, held until ack or withdraw, one dead
  // cycle after ack.
  logic        m_req  [2];
  logic        m_ackd [2];
  logic [31:0] m_mip  [2];
  logic [31:0] m_cause[2];
  logic        eh [8];          // eh[k] = irq_ext sampled k edges ago
  int          stages [2] = '{2, 3};
  bit          edge_m [2] = '{1'b0, 1'b1};
  bit          started = 1'b0;

  task automatic model_step();
    logic [31:0] en, nm;
    logic        clr, rise;
    int          s;
    started = 1'b1;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) eh[k] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_req[i] = 1'b0; m_ackd[i] = 1'b0; m_mip[i] = '0; m_cause[i] = '0;
      end
      return;
    end
    for (int k = 7; k > 0; k--) eh[k] = eh[k-1];
    eh[0] = irq_ext;
    for (int i = 0; i < 2; i++) begin
      s    = stages[i];
      en   = m_mip[i] & mie & {32{mst}};
      clr  = ack && m_req[i] && (m_cause[i][3:0] == 4'd11);
      rise = eh[s] && !eh[s+1];
      nm     = '0;
      nm[3]  = irq_sw;
      nm[7]  = irq_timer;
      nm[11] = edge_m[i] ? (rise || (m_mip[i][11] && !clr)) : eh[s];
      if (m_ackd[i]) begin
        m_ackd[i] = 1'b0;
      end else if (m_req[i]) begin
        if (ack) begin
          m_req[i]  = 1'b0;
          m_ackd[i] = 1'b1;
        end else if (((en >> m_cause[i][3:0]) & 32'd1) == 32'd0) begin
          m_req[i] = 1'b0;
        end
      end else if (en != 32'd0) begin
        m_req[i]   = 1'b1;
        m_cause[i] = en[11] ? 32'h8000_000B : (en[3] ? 32'h8000_0003 : 32'h8000_0007);
      end
      m_mip[i] = nm;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (started) begin
      chk("model_req_lvl",   {31'b0, req0}, {31'b0, m_req[0]});
      chk("model_cause_lvl", cause0, m_cause[0]);
      chk("model_mip_lvl",   mip0, m_mip[0]);
      chk("model_req_edg",   {31'b0, req1}, {31'b0, m_req[1]});
      chk("model_cause_edg", cause1, m_cause[1]);
      chk("model_mip_edg",   mip1, m_mip[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq_sw = 1'b1; irq_timer = 1'b1; irq_ext = 1'b1;
    mst = 1'b1; mie = '1; ack = 1'b0;

    // Reset with every source high
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk("rst_req_lvl", {31'b0, req0}, 32'd0);
      chk("rst_mip_lvl", mip0, 32'd0);
      chk("rst_req_edg", {31'b0, req1}, 32'd0);
      chk("rst_mip_edg", mip1, 32'd0);
    end
    rst_n = 1'b1; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; mie = '0;
    tick(4);

    // Timer, level
    mie = 32'h80; mst = 1'b1; irq_timer = 1'b1;
    tick(1);
    chk("tmr_mip_c1", mip0, 32'h80);
    chk("tmr_req_c1", {31'b0, req0}, 32'd0);
    tick(1);
    chk("tmr_req_c2", {31'b0, req0}, 32'd1);
    chk("tmr_cause_c2", cause0, 32'h8000_0007);
    ack = 1'b1; irq_timer = 1'b0;
    tick(1);
    chk("tmr_acked_req", {31'b0, req0}, 32'd0);
    ack = 1'b0;
    tick(3);
    chk("tmr_idle_req", {31'b0, req1}, 32'd0);

    // Priority: sw and ext together; no re-arbitration inside REQ
    mie = 32'h888; irq_sw = 1'b1; irq_ext = 1'b1;
    tick(2);
    chk("pri_cause_first_lvl", cause0, 32'h8000_0003);
    chk("pri_req_first_edg", {31'b0, req1}, 32'd1);
    tick(1);
    chk("pri_mip_lvl", mip0, 32'h808);
    tick(1);
    chk("pri_mip_edg", mip1, 32'h808);
    tick(1);
    chk("pri_hold_cause", cause0, 32'h8000_0003);
    ack = 1'b1;
    tick(1);
    chk("pri_acked", {31'b0, req0}, 32'd0);
    ack = 1'b0;
    tick(1);
    chk("pri_idle", {31'b0, req0}, 32'd0);
    tick(1);
    chk("pri_next_cause_lvl", cause0, 32'h8000_000B);
    chk("pri_next_cause_edg", cause1, 32'h8000_000B);
    ack = 1'b1;
    tick(1);
    chk("pri_edg_clear_mip", mip1, 32'h008);
    chk("pri_lvl_keep_mip", mip0, 32'h808);
    ack = 1'b0;
    tick(2);
    chk("pri_third_cause_lvl", cause0, 32'h8000_000B);
    chk("pri_third_cause_edg", cause1, 32'h8000_0003);
    irq_sw = 1'b0; irq_ext = 1'b0; ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(6);

    // Withdraw without ack
    mie = 32'h80; irq_timer = 1'b1;
    tick(2);
    chk("wd_req", {31'b0, req0}, 32'd1);
    tick(2);
    irq_timer = 1'b0;
    tick(1);
    chk("wd_req_still", {31'b0, req0}, 32'd1);
    tick(1);
    chk("wd_req_drop", {31'b0, req0}, 32'd0);
    chk("wd_cause_kept", cause0, 32'h8000_0007);

    // Ack coinciding with withdraw takes ACKED (dead cycle before next REQ)
    mie = 32'h88; irq_timer = 1'b1;
    tick(2);
    chk("wa_cause", cause0, 32'h8000_0007);
    irq_timer = 1'b0;
    tick(1);
    ack = 1'b1; irq_sw = 1'b1;
    tick(1);
    chk("wa_req_off", {31'b0, req0}, 32'd0);
    ack = 1'b0;
    tick(1);
    chk("wa_dead_cycle", {31'b0, req0}, 32'd0);
    tick(1);
    chk("wa_next_req", {31'b0, req0}, 32'd1);
    chk("wa_next_cause", cause0, 32'h8000_0003);
    ack = 1'b1; irq_sw = 1'b0;
    tick(1);
    ack = 1'b0;
    tick(4);

    // Edge mode: pulses on irq_ext
    mie = 32'h800; irq_ext = 1'b1;
    tick(1);
    irq_ext = 1'b0;
    tick(2);
    chk("edg_mip_c3", mip1, 32'h0);
    tick(1);
    chk("edg_mip_c4", mip1, 32'h800);
    irq_ext = 1'b1;
    tick(1);
    irq_ext = 1'b0;
    chk("edg_req", {31'b0, req1}, 32'd1);
    chk("edg_cause", cause1, 32'h8000_000B);
    tick(2);
    chk("edg_mip_stays", mip1, 32'h800);
    ack = 1'b1;
    tick(1);
    chk("edg_set_wins", mip1, 32'h800);
    ack = 1'b0;
    tick(2);
    chk("edg_rereq_cause", cause1, 32'h8000_000B);
    chk("edg_rereq", {31'b0, req1}, 32'd1);
    ack = 1'b1;
    tick(1);
    chk("edg_ack_clears", mip1, 32'h0);
    ack = 1'b0;
    tick(4);

    // Masking by mstatus.MIE; ack outside REQ is ignored
    mst = 1'b0; mie = 32'h888; irq_sw = 1'b1; irq_timer = 1'b1; irq_ext = 1'b1;
    tick(6);
    chk("msk_mip_lvl", mip0, 32'h888);
    chk("msk_mip_edg", mip1, 32'h888);
    chk("msk_noreq", {31'b0, req0 | req1}, 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("msk_stray_ack", mip1, 32'h888);
    mst = 1'b1;
    tick(2);
    chk("msk_req_lvl", cause0, 32'h8000_000B);
    chk("msk_req_edg", {31'b0, req1}, 32'd1);

    // Reset mid-handshake
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid_req", {31'b0, req0 | req1}, 32'd0);
    chk("rst_mid_cause", cause1, 32'd0);
    chk("rst_mid_mip", mip0 | mip1, 32'd0);
    rst_n = 1'b1; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
